rvx_ibus_prefetch: RTL and testbench
====================================

RVX_IBUS_PREFETCH -- requirements
Module: rvx_ibus_prefetch

Interface
REQ-001 Parameter BOOT_ADDRESS, default 32'h00000000, first prefetch address after reset.
REQ-002 Parameter DEPTH, default 4, buffer entries; power of two, 2..16.
REQ-003 clock  input  1  rising-edge clock.
REQ-004 reset_n  input  1  synchronous, active-low reset.
REQ-005 core_address  input  32  word-aligned fetch address from core.
REQ-006 core_rrequest  input  1  single-cycle fetch request strobe.
REQ-007 core_rdata  output  32  instruction word to core.
REQ-008 core_rresponse  output  1  single-cycle strobe, core_rdata valid.
REQ-009 mem_address  output  32  word address to instruction memory.
REQ-010 mem_rrequest  output  1  single-cycle memory read strobe.
REQ-011 mem_rdata  input  32  memory read data.
REQ-012 mem_rresponse  input  1  memory data valid, at least 1 cycle after mem_rrequest.

Function
REQ-013 Buffer SHALL hold up to DEPTH consecutive words; head_address is address of oldest entry, fetch_address is next address to request.
REQ-014 At most one memory read SHALL be outstanding; mem_rrequest issued only in IDLE when buffer not full (entries + outstanding < DEPTH).
REQ-015 FSM states: IDLE (no read outstanding), FETCH (valid read outstanding), DISCARD (stale read outstanding).
REQ-016 IDLE->FETCH on mem_rrequest; FETCH->IDLE on mem_rresponse (word pushed, fetch_address += 4); DISCARD->IDLE on mem_rresponse (word dropped).
REQ-017 Hit: core_rrequest with core_address == head_address and buffer non-empty -> core_rresponse next cycle with head word, pop, head_address += 4.
REQ-018 Miss: any other core_rrequest SHALL flush buffer, set head_address = fetch_address = core_address, mark request pending; FETCH becomes DISCARD.
REQ-019 Pending request SHALL be satisfied by the first word pushed at its address, response one cycle after push (or per REQ-028), and that word is popped.
REQ-020 New core_rrequest while one is pending SHALL supersede it; older request never receives a response.
REQ-021 Simultaneous hit pop and mem_rresponse push SHALL both occur; count unchanged.
REQ-022 Address arithmetic modulo 2^32; 32'hFFFFFFFC + 4 wraps to 0.
REQ-023 core_rresponse SHALL never assert without a preceding unanswered core_rrequest.

Reset
REQ-024 On reset: core_rresponse=0, core_rdata=0, mem_rrequest=0, mem_address=BOOT_ADDRESS, FSM=IDLE, buffer empty, no pending request, head/fetch_address=BOOT_ADDRESS.
REQ-025 Reset mid-FETCH SHALL abandon the read; a mem_rresponse in the first cycle after reset SHALL be ignored (state DISCARD entered instead of IDLE if memory read was in flight is not tracked; bench guarantees memory is reset together).
REQ-026 Prefetching SHALL begin from BOOT_ADDRESS the first cycle after reset release.

Configuration
REQ-027 Macro RVX_PREFETCH_BYPASS_EN selects miss-path forwarding.
REQ-028 Defined: word satisfying a pending request SHALL be forwarded combinationally, core_rresponse in same cycle as mem_rresponse, and not pushed.
REQ-029 Undefined: word SHALL be pushed, then served per REQ-017 timing (one cycle later); all outputs registered.

Structure
REQ-030 FSM state encodings (IDLE/FETCH/DISCARD) SHALL live in shared constants header rvx_core_constants.vh.
REQ-031 Storage, pointers and count SHALL be sub-module rvx_prefetch_fifo (push, pop, flush, full, empty, head data).

Verification
REQ-032 Reset release, memory latency 1, no core request -> mem reads 0x0,0x4,0x8,0xC issued, then mem_rrequest stays 0 (DEPTH=4 full).
REQ-033 Buffer full from 0x0, core requests 0x0,0x4 on consecutive cycles -> responses one cycle after each with words from 0x0,0x4; refill from 0x10 starts.
REQ-034 Core requests 0x100 while read of 0x8 outstanding -> 0x8 data dropped, next mem_address=0x100, core response carries word 0x100 (same cycle as mem_rresponse with RVX_PREFETCH_BYPASS_EN, one cycle later without).
REQ-035 Core requests 0x200 then 0x300 before either returns -> exactly one core_rresponse, data from 0x300.
REQ-036 Core requests 0xFFFFFFFC -> after it, fetch continues at 0x00000000.
REQ-037 Hit pop and mem_rresponse in same cycle with 3 entries -> count stays 3, order preserved.

Source files
------------

// File: rtl/rvx_ibus_prefetch_pkg.sv
// rtl/rvx_ibus_prefetch_pkg.sv - types and helpers for the instruction prefetcher
package rvx_ibus_prefetch_pkg;

  `include "rvx_core_constants.vh"

  typedef enum logic [1:0] {
    ST_IDLE    = RVX_FSM_IDLE,
    ST_FETCH   = RVX_FSM_FETCH,
    ST_DISCARD = RVX_FSM_DISCARD
  } fetch_state_t;

  // Word-address increment; wraps modulo 2^32.
  function automatic logic [31:0] next_word(input logic [31:0] address);
    return address + 32'd4;
  endfunction

endpackage

// File: rtl/rvx_core_constants.vh
// rtl/rvx_core_constants.vh - shared instruction-fetch FSM state encodings
`ifndef RVX_CORE_CONSTANTS_VH
`define RVX_CORE_CONSTANTS_VH

localparam logic [1:0] RVX_FSM_IDLE    = 2'd0;
localparam logic [1:0] RVX_FSM_FETCH   = 2'd1;
localparam logic [1:0] RVX_FSM_DISCARD = 2'd2;

`endif

// File: rtl/rvx_prefetch_fifo.sv
// rtl/rvx_prefetch_fifo.sv - word storage, pointers and occupancy for the prefetcher
module rvx_prefetch_fifo #(
  parameter int DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        flush,
  input  logic        push,
  input  logic [31:0] push_data,
  input  logic        pop,
  output logic [31:0] head_data,
  output logic        full,
  output logic        empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [31:0]   store [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;

  assign head_data = store[rd_ptr];
  assign full      = (count == FULL_COUNT);
  assign empty     = (count == '0);

  always_ff @(posedge clock) begin
    if (push && !flush) begin
      store[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

endmodule

// File: rtl/rvx_ibus_prefetch.sv
// rtl/rvx_ibus_prefetch.sv - sequential instruction prefetch buffer between core and memory
// RVX_PREFETCH_BYPASS_EN: forward the word answering a miss to the core in the same cycle.
module rvx_ibus_prefetch
  import rvx_ibus_prefetch_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDRESS = 32'h00000000,
  parameter int          DEPTH        = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] core_address,
  input  logic        core_rrequest,
  output logic [31:0] core_rdata,
  output logic        core_rresponse,
  output logic [31:0] mem_address,
  output logic        mem_rrequest,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rresponse
);

  fetch_state_t state;
  logic [31:0]  head_address;
  logic [31:0]  fetch_address;
  logic         pending;
  logic         resp_q;
  logic [31:0]  rdata_q;

  logic [31:0]  head_data;
  logic         full;
  logic         empty;

  logic hit;
  logic miss;
  logic word_valid;
  logic serve;
  logic push;
  logic issue;

  assign hit        = core_rrequest && !empty && (core_address == head_address);
  assign miss       = core_rrequest && !hit;
  // A word returning in the same cycle as a miss belongs to the old stream.
  assign word_valid = (state == ST_FETCH) && mem_rresponse && !miss;
  // While pending the buffer is empty, so the next valid word is the one asked for.
  assign serve      = word_valid && pending;
  assign push       = word_valid && !pending;
  assign issue      = (state == ST_IDLE) && (miss || !full);

  rvx_prefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .flush     (miss),
    .push      (push),
    .push_data (mem_rdata),
    .pop       (hit),
    .head_data (head_data),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      head_address  <= BOOT_ADDRESS;
      fetch_address <= BOOT_ADDRESS;
      pending       <= 1'b0;
      mem_rrequest  <= 1'b0;
      mem_address   <= BOOT_ADDRESS;
    end else begin
      case (state)
        ST_IDLE:    if (issue) state <= ST_FETCH;
        ST_FETCH:   if (mem_rresponse) state <= ST_IDLE;
                    else if (miss) state <= ST_DISCARD;
        ST_DISCARD: if (mem_rresponse) state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase

      mem_rrequest <= issue;
      if (issue) begin
        mem_address <= miss ? core_address : fetch_address;
      end

      if (miss) begin
        head_address  <= core_address;
        fetch_address <= core_address;
        pending       <= 1'b1;
      end else begin
        if (hit || serve) head_address <= next_word(head_address);
        if (word_valid) fetch_address <= next_word(fetch_address);
        if (serve) pending <= 1'b0;
      end
    end
  end

`ifdef RVX_PREFETCH_BYPASS_EN
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      resp_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      resp_q <= hit;
      if (hit) rdata_q <= head_data;
    end
  end

  assign core_rresponse = resp_q || serve;
  assign core_rdata     = serve ? mem_rdata : rdata_q;
`else
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      resp_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      resp_q <= hit || serve;
      if (hit) rdata_q <= head_data;
      else if (serve) rdata_q <= mem_rdata;
    end
  end

  assign core_rresponse = resp_q;
  assign core_rdata     = rdata_q;
`endif

endmodule

// File: tb/tb_rvx_ibus_prefetch.sv
// tb/tb_rvx_ibus_prefetch.sv - self-checking bench for rvx_ibus_prefetch
module tb_rvx_ibus_prefetch;

  localparam int          DEPTH = 4;
  localparam logic [31:0] BOOT  = 32'h00000000;
`ifdef RVX_PREFETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] core_address;
  logic        core_rrequest;
  logic [31:0] core_rdata;
  logic        core_rresponse;
  logic [31:0] mem_address;
  logic        mem_rrequest;
  logic [31:0] mem_rdata;
  logic        mem_rresponse;

  always #5 clock = ~clock;

  rvx_ibus_prefetch #(.BOOT_ADDRESS(BOOT), .DEPTH(DEPTH)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .core_address   (core_address),
    .core_rrequest  (core_rrequest),
    .core_rdata     (core_rdata),
    .core_rresponse (core_rresponse),
    .mem_address    (mem_address),
    .mem_rrequest   (mem_rrequest),
    .mem_rdata      (mem_rdata),
    .mem_rresponse  (mem_rresponse)
  );

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input bit ok, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // Memory: answers each read mem_lat cycles after the request cycle.
  int          mem_lat = 1;
  int          mem_cnt = 0;
  logic [31:0] mem_addr_q;

  always @(posedge clock) begin
    #2;
    if (!reset_n) begin
      mem_rresponse = 1'b0;
      mem_cnt = 0;
    end else begin
      mem_rresponse = 1'b0;
      if (mem_cnt > 0) begin
        mem_cnt--;
        if (mem_cnt == 0) begin
          mem_rresponse = 1'b1;
          mem_rdata = word(mem_addr_q);
        end
      end
      if (mem_rrequest) begin
        mem_cnt = mem_lat;
        mem_addr_q = mem_address;
      end
    end
  end

  // Behavioural model: buffer as a queue of addresses, one outstanding read.
  bit          m_out, m_stale, m_pend, exp_resp;
  logic [31:0] m_head, m_fetch, exp_data;
  logic [31:0] m_buf [$];
  logic [31:0] resp_log [$];
  logic [31:0] req_log [$];
  int          resp_cyc [$];
  int          cyc = 0;

  always @(negedge clock) begin
    bit er, hit, miss, good;
    logic [31:0] ed;
    cyc++;
    if (!reset_n) begin
      m_out = 0; m_stale = 0; m_pend = 0; exp_resp = 0;
      m_head = BOOT; m_fetch = BOOT;
      m_buf.delete();
    end else begin
      if (mem_rrequest) begin
        check("mem_one_outstanding", !m_out, 32'(m_out), 32'd0);
        check("mem_room", m_buf.size() < DEPTH, m_buf.size(), DEPTH - 1);
        check("mem_address", mem_address == m_fetch, mem_address, m_fetch);
        req_log.push_back(mem_address);
        m_out = 1; m_stale = 0;
      end
      hit  = core_rrequest && m_buf.size() > 0 && core_address == m_head;
      miss = core_rrequest && !hit;
      good = mem_rresponse && m_out && !m_stale && !miss;
      er = exp_resp; ed = exp_data;
      if (BYP && good && m_pend) begin er = 1; ed = word(m_head); end
      check("core_rresponse", core_rresponse == er, 32'(core_rresponse), 32'(er));
      if (er) check("core_rdata", core_rdata == ed, core_rdata, ed);
      if (core_rresponse) begin
        resp_log.push_back(core_rdata);
        resp_cyc.push_back(cyc);
      end
      exp_resp = 0;
      if (good) begin
        if (m_pend) begin
          if (!BYP) begin exp_resp = 1; exp_data = word(m_head); end
          m_head += 4; m_pend = 0;
        end else begin
          m_buf.push_back(m_fetch);
        end
        m_fetch += 4;
      end
      if (mem_rresponse) begin m_out = 0; m_stale = 0; end
      if (hit) begin
        exp_resp = 1; exp_data = word(m_buf.pop_front()); m_head += 4;
      end
      if (miss) begin
        m_buf.delete();
        m_head = core_address; m_fetch = core_address; m_pend = 1;
        if (m_out) m_stale = 1;
      end
    end
  end

  task automatic tick();
    @(posedge clock); #1;
    core_rrequest = 1'b0;
  endtask

  task automatic req(input logic [31:0] a);
    tick();
    core_rrequest = 1'b1;
    core_address = a;
  endtask

  task automatic do_reset();
    tick(); reset_n = 1'b0;
    tick(); tick();
    check("rst_core_rresponse", core_rresponse == 1'b0, 32'(core_rresponse), 32'd0);
    check("rst_core_rdata", core_rdata == 32'd0, core_rdata, 32'd0);
    check("rst_mem_rrequest", mem_rrequest == 1'b0, 32'(mem_rrequest), 32'd0);
    check("rst_mem_address", mem_address == BOOT, mem_address, BOOT);
    tick(); reset_n = 1'b1;
    req_log.delete(); resp_log.delete(); resp_cyc.delete();
  endtask

  task automatic wait_req(input logic [31:0] a, input int lim);
    bit found = 0;
    for (int i = 0; i < lim && !found; i++) begin
      tick();
      if (mem_rrequest && mem_address == a) found = 1;
    end
    check("wait_req", found, a, a);
  endtask

  function automatic int find_req(input logic [31:0] a);
    for (int i = 0; i < req_log.size(); i++) if (req_log[i] == a) return i;
    return -1;
  endfunction

  initial begin
    int k;
    reset_n = 1'b0; core_rrequest = 1'b0; core_address = '0;
    mem_rresponse = 1'b0; mem_rdata = '0;
    do_reset();

    // Fill from boot address, then stall when full.
    repeat (30) tick();
    check("fill_count", req_log.size() == 4, req_log.size(), 4);
    if (req_log.size() == 4) begin
      check("fill_0", req_log[0] == 32'h0, req_log[0], 32'h0);
      check("fill_1", req_log[1] == 32'h4, req_log[1], 32'h4);
      check("fill_2", req_log[2] == 32'h8, req_log[2], 32'h8);
      check("fill_3", req_log[3] == 32'hC, req_log[3], 32'hC);
    end

    // Two back-to-back hits, then refill from 0x10.
    req(32'h0); req(32'h4);
    repeat (10) tick();
    check("hit_count", resp_log.size() == 2, resp_log.size(), 2);
    if (resp_log.size() == 2) begin
      check("hit_data0", resp_log[0] == 32'hC0DE0000, resp_log[0], 32'hC0DE0000);
      check("hit_data1", resp_log[1] == 32'hC0DE0004, resp_log[1], 32'hC0DE0004);
      check("hit_spacing", resp_cyc[1] - resp_cyc[0] == 1, resp_cyc[1] - resp_cyc[0], 1);
    end
    check("refill_addr", req_log.size() > 4 && req_log[4] == 32'h10, req_log.size() > 4 ? req_log[4] : 32'hX, 32'h10);

    // Pop and push in the same cycle with three entries.
    do_reset();
    repeat (30) tick();
    req(32'h0); tick(); tick();
    req(32'h4);
    #2;
    check("simul_push", mem_rresponse == 1'b1, 32'(mem_rresponse), 32'd1);
    req(32'h8); req(32'hC); req(32'h10);
    repeat (4) tick();
    check("simul_count", resp_log.size() == 5, resp_log.size(), 5);
    for (int i = 0; i < 5 && i < resp_log.size(); i++)
      check("simul_order", resp_log[i] == (32'hC0DE0000 | 32'(4 * i)), resp_log[i], 32'hC0DE0000 | 32'(4 * i));

    // Miss while read of 0x8 is outstanding.
    mem_lat = 3;
    do_reset();
    wait_req(32'h8, 40);
    req(32'h100);
    repeat (15) tick();
    check("miss_count", resp_log.size() == 1, resp_log.size(), 1);
    if (resp_log.size() == 1) check("miss_data", resp_log[0] == 32'hC0DE0100, resp_log[0], 32'hC0DE0100);
    k = find_req(32'h8);
    check("miss_next_addr", k >= 0 && k + 1 < req_log.size() && req_log[k+1] == 32'h100,
          (k >= 0 && k + 1 < req_log.size()) ? req_log[k+1] : 32'hX, 32'h100);

    // Superseded request never answered.
    resp_log.delete();
    req(32'h200); tick(); req(32'h300);
    repeat (20) tick();
    check("super_count", resp_log.size() == 1, resp_log.size(), 1);
    if (resp_log.size() == 1) check("super_data", resp_log[0] == 32'hC0DE0300, resp_log[0], 32'hC0DE0300);

    // Address wrap.
    resp_log.delete(); req_log.delete();
    req(32'hFFFFFFFC);
    repeat (20) tick();
    check("wrap_resp", resp_log.size() == 1 && resp_log[0] == 32'h3F21FFFC,
          resp_log.size() > 0 ? resp_log[0] : 32'hX, 32'h3F21FFFC);
    k = find_req(32'hFFFFFFFC);
    check("wrap_next", k >= 0 && k + 1 < req_log.size() && req_log[k+1] == 32'h0,
          (k >= 0 && k + 1 < req_log.size()) ? req_log[k+1] : 32'hX, 32'h0);

    // Reset while a read is in flight; memory resets alongside.
    req(32'h40);
    wait_req(32'h40, 10);
    tick();
    do_reset();
    wait_req(32'h0, 10);
    repeat (10) tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=%0d required=%0d", checks, 0);
    $fatal(1);
  end

endmodule
